keypad_scanner: RTL and testbench

- Drives the 4x3 matrix keypad and delivers a debounced 4-bit key code on the `keypad` input of the vending-machine `fsm`.
- Row strobing, column sampling, debounce and code encoding all live here, so the FSM sees a clean code that is held while a key is down and returns to 0 when it is released.
- Sits between the keypad pins and `fsm.keypad`.

---
 rtl/keypad_pkg.sv | 20 ++
 rtl/col_sync.sv | 23 ++
 rtl/keypad_scanner.sv | 121 ++++++++++++
 tb/tb_keypad_scanner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x3 matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        DEBOUNCE   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [3:0] KEY_NONE = 4'd0;
    localparam int         ROWS     = 4;
    localparam int         COLS     = 3;

    // Row-major numbering starting at 1, so 0 stays free for "no key".
    function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
        return {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchronizer; resets to all-ones so idle pulled-up lines read as released.
module col_sync #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw,
    output logic [WIDTH-1:0] synced
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta   <= '1;
            synced <= '1;
        end else begin
            meta   <= raw;
            synced <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Row-strobing 4x3 keypad scanner with press/release debounce; presents a held
// key code (0 = none) plus a one-cycle key_valid pulse per accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [COLS-1:0] col_sense,
    output logic [ROWS-1:0] row_drive,
    output logic [3:0]      keypad,
    output logic            key_valid,
    output logic            key_held
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DEB_DONE  = DW'(DEBOUNCE_CNT);

    state_t          state;
    logic [1:0]      row;
    logic [1:0]      col;
    logic [SW-1:0]   scan_cnt;
    logic [DW-1:0]   deb_cnt;
    logic [COLS-1:0] cs;
    logic [3:0]      cs_ext;
    logic            col_open;

    col_sync #(.WIDTH(COLS)) u_col_sync (
        .clk    (clk),
        .reset  (reset),
        .raw    (col_sense),
        .synced (cs)
    );

    function automatic logic [1:0] first_low(input logic [COLS-1:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else            return 2'd2;
    endfunction

    assign row_drive = ~(4'b0001 << row);
    // Padding bit keeps the latched-column lookup in range for any 2-bit index.
    assign cs_ext    = {1'b1, cs};
    assign col_open  = cs_ext[col];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            row       <= 2'd0;
            col       <= 2'd0;
            scan_cnt  <= '0;
            deb_cnt   <= '0;
            keypad    <= KEY_NONE;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    // Columns are only trusted at the end of the slot, after settling.
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (cs != 3'b111) begin
                            col     <= first_low(cs);
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end else begin
                            row <= row + 2'd1;
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (col_open) begin
                        state    <= SCAN;
                        row      <= row + 2'd1;
                        scan_cnt <= '0;
                        deb_cnt  <= '0;
                    end else if (deb_cnt == DEB_DONE) begin
                        state     <= PRESSED;
                        deb_cnt   <= '0;
                        keypad    <= key_code(row, col);
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                PRESSED: begin
                    if (col_open) begin
                        state   <= RELEASE_DB;
                        deb_cnt <= '0;
                    end
                end
                RELEASE_DB: begin
                    // A re-close during release bounce resumes the held key silently.
                    if (!col_open) begin
                        state   <= PRESSED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_DONE) begin
                        state    <= SCAN;
                        row      <= 2'd0;
                        scan_cnt <= '0;
                        deb_cnt  <= '0;
                        keypad   <= KEY_NONE;
                        key_held <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + DW'(1);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a key-matrix model drives col_sense from row_drive,
// table-driven key checks, hand sequences for bounce/reset cases, random presses.
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [2:0] col_sense;
    logic [3:0] row_drive;
    logic [3:0] keypad;
    logic       key_valid;
    logic       key_held;

    logic [3:0][2:0] keys;
    int n_cmp, n_bad, kv_count;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
        logic [3:0] rows;
    } key_vec_t;

    key_vec_t   kv_tbl[12];
    logic [3:0] scan_tbl[16];

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CNT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .col_sense (col_sense),
        .row_drive (row_drive),
        .keypad    (keypad),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A closed key on a driven (low) row pulls its column low.
    always_comb begin
        col_sense = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (keys[r][c] && !row_drive[r]) col_sense[c] = 1'b0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int r, input int c);
        keys = '0;
        keys[r][c] = 1'b1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (key_valid !== 1'b1 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(key_valid), 1);
    endtask

    task automatic wait_clear(input string name);
        int n = 0;
        while (keypad !== 4'd0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(keypad), 0);
    endtask

    task automatic wait_row(input string name, input logic [3:0] target);
        int n = 0;
        while (row_drive !== target && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(row_drive), 32'(target));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row_drive"}, 32'(row_drive), 'b1110);
        chk({tag, "_keypad"},    32'(keypad), 0);
        chk({tag, "_key_valid"}, 32'(key_valid), 0);
        chk({tag, "_key_held"},  32'(key_held), 0);
    endtask

    // Invariants and pulse counting, sampled between edges.
    always @(posedge clk) begin
        #2;
        if (reset) begin
            if (key_valid) kv_count++;
            chk("one_cold_rows", 32'($countones(~row_drive)), 1);
            chk("code_range", 32'(keypad <= 4'd12), 1);
            chk("held_matches_code", 32'(key_held), 32'(keypad != 4'd0));
        end
    end

    initial begin
        int kv0;
        int r, c, hold;
        n_cmp = 0; n_bad = 0; kv_count = 0;
        keys  = '0;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            kv_tbl[i].r    = i / 3;
            kv_tbl[i].c    = i % 3;
            kv_tbl[i].code = 4'(i + 1);
            kv_tbl[i].rows = ~(4'b0001 << (i / 3));
        end
        for (int k = 0; k < 16; k++) scan_tbl[k] = ~(4'b0001 << (k / 4));

        cycles(2);
        chk_reset_vals("reset");
        reset = 1'b1;
        for (int k = 0; k < 16; k++) begin
            chk("scan_order", 32'(row_drive), 32'(scan_tbl[k]));
            @(negedge clk);
        end

        // Reset in the middle of row 1's slot.
        cycles(5);
        chk("pre_reset_row1", 32'(row_drive), 'b1101);
        #2 reset = 1'b0;
        #1 chk_reset_vals("midscan");
        @(negedge clk);
        reset = 1'b1;

        // Stable press of row1/col2.
        press(1, 2);
        wait_valid("press6_valid");
        chk("press6_code", 32'(keypad), 6);
        chk("press6_held", 32'(key_held), 1);
        chk("press6_row", 32'(row_drive), 'b1101);
        @(negedge clk);
        chk("press6_pulse_width", 32'(key_valid), 0);
        cycles(6);
        chk("press6_hold_code", 32'(keypad), 6);
        chk("press6_frozen_row", 32'(row_drive), 'b1101);

        // Release bounce: open 3, close 10, open.
        kv0 = kv_count;
        keys = '0;
        cycles(3);
        press(1, 2);
        cycles(10);
        chk("relbounce_hold", 32'(keypad), 6);
        keys = '0;
        cycles(6);
        chk("relbounce_early", 32'(keypad), 6);
        cycles(7);
        chk("relbounce_code", 32'(keypad), 0);
        chk("relbounce_held", 32'(key_held), 0);
        chk("relbounce_row", 32'(row_drive), 'b1110);
        chk("relbounce_no_valid", 32'(kv_count - kv0), 0);

        // Short bounce aligned to the start of a row-0 slot.
        wait_row("sync_row3", 4'b0111);
        wait_row("sync_row0", 4'b1110);
        kv0 = kv_count;
        press(0, 0);
        cycles(5);
        keys = '0;
        wait_row("bounce_resume", 4'b1101);
        cycles(20);
        chk("bounce_no_valid", 32'(kv_count - kv0), 0);
        chk("bounce_code", 32'(keypad), 0);

        // Two keys on row 0, then a later key on row 3 while held.
        kv0 = kv_count;
        keys = '0;
        keys[0][0] = 1'b1;
        keys[0][2] = 1'b1;
        wait_valid("conflict_valid");
        chk("conflict_code", 32'(keypad), 1);
        keys[3][1] = 1'b1;
        cycles(30);
        chk("rollover_code", 32'(keypad), 1);
        chk("rollover_row", 32'(row_drive), 'b1110);
        chk("rollover_one_valid", 32'(kv_count - kv0), 1);
        keys = '0;
        wait_clear("conflict_release");

        // Reset while the debounce counter is at 5.
        reset = 1'b0;
        press(0, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (9) @(posedge clk);
        #3;
        chk("middeb_code_pre", 32'(keypad), 0);
        reset = 1'b0;
        #1 chk_reset_vals("middeb");
        @(negedge clk);
        reset = 1'b1;
        kv0 = kv_count;
        wait_valid("reacq_valid");
        chk("reacq_code", 32'(keypad), 1);
        cycles(30);
        chk("reacq_one_valid", 32'(kv_count - kv0), 1);
        chk("reacq_held", 32'(key_held), 1);
        keys = '0;
        wait_clear("reacq_release");

        // Every key position from the table.
        for (int i = 0; i < 12; i++) begin
            press(kv_tbl[i].r, kv_tbl[i].c);
            wait_valid("tbl_valid");
            chk("tbl_code", 32'(keypad), 32'(kv_tbl[i].code));
            chk("tbl_held", 32'(key_held), 1);
            chk("tbl_row", 32'(row_drive), 32'(kv_tbl[i].rows));
            @(negedge clk);
            chk("tbl_pulse_width", 32'(key_valid), 0);
            keys = '0;
            wait_clear("tbl_release");
            chk("tbl_release_held", 32'(key_held), 0);
            chk("tbl_release_row", 32'(row_drive), 'b1110);
        end

        // Random presses with occasional short glitches beforehand.
        for (int it = 0; it < 20; it++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                press($urandom_range(0, 3), $urandom_range(0, 2));
                cycles($urandom_range(1, 3));
                keys = '0;
                cycles(4);
            end
            kv0 = kv_count;
            press(r, c);
            wait_valid("rand_valid");
            chk("rand_code", 32'(keypad), 32'(r * 3 + c + 1));
            hold = $urandom_range(0, 20);
            cycles(hold);
            chk("rand_hold_code", 32'(keypad), 32'(r * 3 + c + 1));
            keys = '0;
            wait_clear("rand_release");
            chk("rand_one_valid", 32'(kv_count - kv0), 1);
            cycles($urandom_range(0, 6));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
